// File: rtl/exec_ctrl_fsm_pkg.sv
// Shared definitions for the execution control FSM.
// State encodings are also used by the datapath and the bench.
package exec_ctrl_fsm_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH    = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD_REG = 3'd2;
  localparam logic [STATE_W-1:0] ST_ALU      = 3'd3;
  localparam logic [STATE_W-1:0] ST_MEM      = 3'd4;
  localparam logic [STATE_W-1:0] ST_WB       = 3'd5;
  localparam logic [STATE_W-1:0] ST_HALT     = 3'd6;
  localparam logic [STATE_W-1:0] ST_FAULT    = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_LOAD_REG = ST_LOAD_REG,
    S_ALU      = ST_ALU,
    S_MEM      = ST_MEM,
    S_WB       = ST_WB,
    S_HALT     = ST_HALT,
    S_FAULT    = ST_FAULT
  } state_t;

  function automatic logic is_busy(input state_t s);
    return !(s == S_IDLE || s == S_HALT || s == S_FAULT);
  endfunction

endpackage

// File: rtl/exec_ctrl_fsm_wait_timer.sv
// Memory-wait timeout counter, shared by the FETCH and MEM states.
// TIMEOUT of 0 disables the hit output.
module exec_ctrl_fsm_wait_timer #(
  parameter int TIMEOUT  = 15,
  parameter int TO_CNT_W = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam logic [TO_CNT_W-1:0] LP_LAST = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (TIMEOUT != 0) && (r_cnt == LP_LAST);

endmodule

// File: rtl/exec_ctrl_fsm.sv
// Execution control FSM: fetch, operand load, ALU, optional memory,
// write-back, halt and fault handling with a retired-instruction count.
module exec_ctrl_fsm
  import exec_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT       = 15,
  parameter int TO_CNT_W      = 4,
  parameter int HAS_MEM_STAGE = 1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               condition_code_check,
  input  logic               is_mem_op,
  input  logic               is_halt_op,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic [STATE_W-1:0] current_state,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               pc_inc,
  output logic               reg_load_en,
  output logic               alu_en,
  output logic               wb_en,
  output logic               busy,
  output logic               fault,
  output logic [CNT_W-1:0]   instr_count
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_fetch_tgt;
  logic             r_halt_pend;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_imem_req;
  logic             r_dmem_req;
  logic             r_reg_load_en;
  logic             r_alu_en;
  logic             r_wb_en;
  logic             r_busy;
  logic             r_fault;
  logic             w_wait_ack;
  logic             w_to_en;
  logic             w_to_clr;
  logic             w_to_hit;
  logic             w_retire;

  // Every "next instruction" path diverts to HALT when one is requested.
  always_comb begin
    w_fetch_tgt = (r_halt_pend || halt_req) ? S_HALT : S_FETCH;
    w_next      = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack)      w_next = S_LOAD_REG;
        else if (w_to_hit) w_next = S_FAULT;
      end
      S_LOAD_REG: begin
        if (is_halt_op)                 w_next = S_HALT;
        else if (!condition_code_check) w_next = w_fetch_tgt;
        else                            w_next = S_ALU;
      end
      S_ALU: begin
        if (HAS_MEM_STAGE != 0 && is_mem_op) w_next = S_MEM;
        else                                 w_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)      w_next = S_WB;
        else if (w_to_hit) w_next = S_FAULT;
      end
      S_WB: begin
        w_next = w_fetch_tgt;
      end
      S_HALT: begin
        if (start) w_next = S_FETCH;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_wait_ack = (r_state == S_FETCH) ? imem_ack : dmem_ack;
    w_to_en    = (r_state == S_FETCH || r_state == S_MEM) && !w_wait_ack;
    w_to_clr   = (w_next != r_state) &&
                 (w_next == S_FETCH || w_next == S_MEM);
    w_retire   = (r_state == S_WB) ||
                 (r_state == S_LOAD_REG && is_halt_op);
  end

  exec_ctrl_fsm_wait_timer #(
    .TIMEOUT  (TIMEOUT),
    .TO_CNT_W (TO_CNT_W)
  ) u_wait_timer (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_to_clr),
    .i_en  (w_to_en),
    .o_hit (w_to_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_halt_pend   <= 1'b0;
      r_instr_count <= '0;
      r_imem_req    <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_reg_load_en <= 1'b0;
      r_alu_en      <= 1'b0;
      r_wb_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_HALT) begin
        r_halt_pend <= 1'b0;
      end else if (halt_req && is_busy(r_state)) begin
        r_halt_pend <= 1'b1;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
      r_imem_req    <= (w_next == S_FETCH);
      r_dmem_req    <= (w_next == S_MEM);
      r_reg_load_en <= (w_next == S_LOAD_REG);
      r_alu_en      <= (w_next == S_ALU);
      r_wb_en       <= (w_next == S_WB);
      r_busy        <= is_busy(w_next);
      r_fault       <= (w_next == S_FAULT);
    end
  end

  assign current_state = r_state;
  assign imem_req      = r_imem_req;
  assign dmem_req      = r_dmem_req;
  assign pc_inc        = (r_state == S_FETCH) && imem_ack;
  assign reg_load_en   = r_reg_load_en;
  assign alu_en        = r_alu_en;
  assign wb_en         = r_wb_en;
  assign busy          = r_busy;
  assign fault         = r_fault;
  assign instr_count   = r_instr_count;

endmodule

// File: tb/tb_exec_ctrl_fsm.sv
// Scoreboard bench for exec_ctrl_fsm: default build plus a
// no-MEM-stage, 2-bit-counter build driven by the same stimulus.
module tb_exec_ctrl_fsm;
  import exec_ctrl_fsm_pkg::*;

  logic clk;
  logic rst, start, halt_req, cc, mem_op, halt_op, imem_ack, dmem_ack;

  logic [2:0]  a_state;
  logic        a_ireq, a_dreq, a_pc, a_rl, a_alu, a_wb, a_busy, a_fault;
  logic [15:0] a_cnt;

  logic [2:0]  b_state;
  logic        b_ireq, b_dreq, b_pc, b_rl, b_alu, b_wb, b_busy, b_fault;
  logic [1:0]  b_cnt;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  outs;
    logic [15:0] cnt;
    logic        chk_b;
    logic [2:0]  bst;
    logic [7:0]  bouts;
    logic [1:0]  bcnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  exec_ctrl_fsm u_dut_a (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .condition_code_check(cc), .is_mem_op(mem_op),
    .is_halt_op(halt_op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .current_state(a_state), .imem_req(a_ireq), .dmem_req(a_dreq),
    .pc_inc(a_pc), .reg_load_en(a_rl), .alu_en(a_alu), .wb_en(a_wb),
    .busy(a_busy), .fault(a_fault), .instr_count(a_cnt)
  );

  exec_ctrl_fsm #(
    .TIMEOUT(15), .TO_CNT_W(4), .HAS_MEM_STAGE(0), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .condition_code_check(cc), .is_mem_op(mem_op),
    .is_halt_op(halt_op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .current_state(b_state), .imem_req(b_ireq), .dmem_req(b_dreq),
    .pc_inc(b_pc), .reg_load_en(b_rl), .alu_en(b_alu), .wb_en(b_wb),
    .busy(b_busy), .fault(b_fault), .instr_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, dmem_req, pc_inc, reg_load_en, alu_en, wb_en, busy, fault}
  function automatic logic [7:0] outs_of(input logic [2:0] st,
                                         input logic ia);
    logic [7:0] o;
    o[7] = (st == ST_FETCH);
    o[6] = (st == ST_MEM);
    o[5] = (st == ST_FETCH) && ia;
    o[4] = (st == ST_LOAD_REG);
    o[3] = (st == ST_ALU);
    o[2] = (st == ST_WB);
    o[1] = (st >= ST_FETCH) && (st <= ST_WB);
    o[0] = (st == ST_FAULT);
    return o;
  endfunction

  task automatic step(input logic r, s, hr, c, m, h, ia, da,
                      input logic [2:0] es, input int ec,
                      input int bs = -1, input int bc = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; start = s; halt_req = hr; cc = c;
    mem_op = m; halt_op = h; imem_ack = ia; dmem_ack = da;
    e.st    = es;
    e.outs  = outs_of(es, ia);
    e.cnt   = ec[15:0];
    e.chk_b = (bs >= 0);
    e.bst   = bs[2:0];
    e.bouts = outs_of(bs[2:0], ia);
    e.bcnt  = bc[1:0];
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] ao, bo;
      logic bad;
      e   = q.pop_front();
      ao  = {a_ireq, a_dreq, a_pc, a_rl, a_alu, a_wb, a_busy, a_fault};
      bo  = {b_ireq, b_dreq, b_pc, b_rl, b_alu, b_wb, b_busy, b_fault};
      bad = 1'b0;
      n_vec++;
      if (a_state !== e.st || ao !== e.outs || a_cnt !== e.cnt) begin
        bad = 1'b1;
        $display("FAIL vec%0d dutA: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 n_vec, a_state, ao, a_cnt, e.st, e.outs, e.cnt);
      end
      if (e.chk_b &&
          (b_state !== e.bst || bo !== e.bouts || b_cnt !== e.bcnt)) begin
        bad = 1'b1;
        $display("FAIL vec%0d dutB: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 n_vec, b_state, bo, b_cnt, e.bst, e.bouts, e.bcnt);
      end
      if (bad) n_err++;
    end
  end

  initial begin
    rst = 1'b1; start = 0; halt_req = 0; cc = 0;
    mem_op = 0; halt_op = 0; imem_ack = 0; dmem_ack = 0;

    // reset, then three zero-wait non-mem instructions
    step(1,0,0,0,0,0,0,0, ST_IDLE, 0, ST_IDLE, 0);
    step(0,1,0,0,0,0,0,0, ST_IDLE, 0, ST_IDLE, 0);
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,1,0,0,1,0, ST_FETCH,    i, ST_FETCH,    i);
      step(0,0,0,1,0,0,1,0, ST_LOAD_REG, i, ST_LOAD_REG, i);
      step(0,0,0,1,0,0,1,0, ST_ALU,      i, ST_ALU,      i);
      step(0,0,0,1,0,0,1,0, ST_WB,       i, ST_WB,       i);
    end

    // mem op, dmem_ack on the 4th MEM cycle; dutB skips MEM and wraps
    step(0,0,0,1,1,0,1,0, ST_FETCH,    3, ST_FETCH,    3);
    step(0,0,0,1,1,0,1,0, ST_LOAD_REG, 3, ST_LOAD_REG, 3);
    step(0,0,0,1,1,0,0,0, ST_ALU,      3, ST_ALU,      3);
    step(0,0,0,1,1,0,0,0, ST_MEM,      3, ST_WB,       3);
    step(0,0,0,1,1,0,0,0, ST_MEM,      3, ST_FETCH,    0);
    step(0,0,0,1,1,0,0,0, ST_MEM,      3);
    step(0,0,0,1,1,0,0,1, ST_MEM,      3);
    step(0,0,0,1,0,0,0,0, ST_WB,       3);

    // condition fails: skipped, not counted
    step(0,0,0,0,0,0,1,0, ST_FETCH,    4);
    step(0,0,0,0,0,0,0,0, ST_LOAD_REG, 4);

    // halt_req during ALU retires then halts
    step(0,0,0,1,0,0,1,0, ST_FETCH,    4);
    step(0,0,0,1,0,0,0,0, ST_LOAD_REG, 4);
    step(0,0,1,1,0,0,0,0, ST_ALU,      4);
    step(0,0,0,1,0,0,0,0, ST_WB,       4);
    step(0,0,0,0,0,0,0,0, ST_HALT,     5);
    step(0,1,0,0,0,0,0,0, ST_HALT,     5);
    step(0,0,0,1,0,0,1,0, ST_FETCH,    5);
    step(0,0,0,1,0,0,0,0, ST_LOAD_REG, 5);
    step(0,0,0,1,0,0,0,0, ST_ALU,      5);
    step(0,0,0,1,0,0,0,0, ST_WB,       5);

    // HALT instruction counts; start+halt_req in HALT resumes cleanly
    step(0,0,0,1,0,0,1,0, ST_FETCH,    6);
    step(0,0,0,1,0,1,0,0, ST_LOAD_REG, 6);
    step(0,1,1,0,0,0,0,0, ST_HALT,     7);
    step(0,0,0,0,0,0,1,0, ST_FETCH,    7);
    step(0,0,0,0,0,0,0,0, ST_LOAD_REG, 7);

    // 15 ack-less FETCH cycles -> FAULT; start ignored; rst recovers
    for (int k = 0; k < 15; k++)
      step(0,1,0,0,0,0,0,0, ST_FETCH, 7);
    step(0,1,0,0,0,0,0,0, ST_FAULT, 7);
    step(0,1,0,0,0,0,0,0, ST_FAULT, 7);
    step(1,0,0,0,0,0,0,0, ST_IDLE,  0, ST_IDLE, 0);

    // ack on the 15th cycle wins over the timeout
    step(0,1,0,0,0,0,0,0, ST_IDLE, 0, ST_IDLE, 0);
    for (int k = 0; k < 14; k++)
      step(0,0,0,1,1,0,0,0, ST_FETCH, 0, ST_FETCH, 0);
    step(0,0,0,1,1,0,1,0, ST_FETCH,    0, ST_FETCH,    0);
    step(0,0,0,1,1,0,0,0, ST_LOAD_REG, 0, ST_LOAD_REG, 0);
    step(0,0,0,1,1,0,0,0, ST_ALU,      0, ST_ALU,      0);
    step(0,0,0,1,1,0,0,0, ST_MEM,      0, ST_WB,       0);
    step(0,0,0,1,1,0,0,0, ST_MEM,      0);

    // async reset mid-MEM clears before the next edge
    step(1,0,0,1,1,0,0,0, ST_IDLE, 0, ST_IDLE, 0);

    // halt_req ignored in IDLE
    step(0,0,1,0,0,0,0,0, ST_IDLE,     0, ST_IDLE,     0);
    step(0,1,0,0,0,0,0,0, ST_IDLE,     0, ST_IDLE,     0);
    step(0,0,0,0,0,0,1,0, ST_FETCH,    0, ST_FETCH,    0);
    step(0,0,0,0,0,0,0,0, ST_LOAD_REG, 0, ST_LOAD_REG, 0);
    step(0,0,0,0,0,0,0,0, ST_FETCH,    0, ST_FETCH,    0);

    for (int k = 0; k < 10 && q.size() != 0; k++)
      @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d vectors left, expected 0", q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_fsm.md
Name: exec_ctrl_fsm

Overview:
Parametrised successor to the processor's IDLE/FETCH/LOAD_REG/ALU control FSM.
- Adds handshaked instruction and data memory access, an optional memory stage, and an explicit write-back stage.
- Adds halt (request and instruction), a fault state with wait timeout, and a retired-instruction counter.
- Sits between program RAM, data RAM, register file and ALU; drives their enables from state.

Parameters:
- TIMEOUT, 15: max cycles waiting for imem_ack/dmem_ack before FAULT; 0 disables the timeout.
- TO_CNT_W, 4: timeout counter width; must hold TIMEOUT.
- HAS_MEM_STAGE, 1: 1 enables the MEM state; 0 means is_mem_op is ignored.
- CNT_W, 16: width of instr_count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin execution from IDLE, or resume from HALT
- halt_req  in  1  external halt request (pulse)
- condition_code_check  in  1  current instruction's condition passes (valid in LOAD_REG)
- is_mem_op  in  1  decoded instruction is load/store (valid in ALU)
- is_halt_op  in  1  decoded instruction is HALT (valid in LOAD_REG)
- imem_ack  in  1  program RAM data valid
- dmem_ack  in  1  data RAM access complete
- current_state  out  3  state encoding
- imem_req  out  1  program RAM request
- dmem_req  out  1  data RAM request
- pc_inc  out  1  increment program counter (1-cycle pulse)
- reg_load_en  out  1  register-file read/operand load
- alu_en  out  1  ALU compute enable
- wb_en  out  1  register write-back enable
- busy  out  1  executing (state not IDLE, HALT or FAULT)
- fault  out  1  in FAULT state
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- State encodings: IDLE=0, FETCH=1, LOAD_REG=2, ALU=3, MEM=4, WB=5, HALT=6, FAULT=7. Registered state, combinational next-state.
- Reset (asynchronous, any time, including mid-wait): state=IDLE, timeout count=0, halt_pending=0, instr_count=0. All outputs 0 except current_state=0.
- Moore outputs:
  - imem_req=1 in FETCH; reg_load_en=1 in LOAD_REG; alu_en=1 in ALU; dmem_req=1 in MEM; wb_en=1 in WB; fault=1 in FAULT.
  - pc_inc is Mealy: 1 in the cycle FETCH and imem_ack are both high.
- halt_pending: set by halt_req in any state except IDLE, HALT and FAULT. Cleared on entry to HALT.
- "Go to FETCH" below means: go to HALT if halt_pending or halt_req is high that cycle; otherwise go to FETCH.
- Transitions:
  - IDLE: start -> FETCH; otherwise stay. halt_req is ignored.
  - FETCH: imem_ack -> LOAD_REG. Otherwise, if the timeout is hit -> FAULT; else stay.
  - LOAD_REG: is_halt_op -> HALT, and the instruction counts as retired. Else if condition_code_check=0 -> go to FETCH; the instruction is skipped and not counted. Else -> ALU.
  - ALU: HAS_MEM_STAGE=1 and is_mem_op -> MEM; otherwise -> WB.
  - MEM: dmem_ack -> WB. Otherwise, if the timeout is hit -> FAULT; else stay.
  - WB: instr_count += 1, then go to FETCH.
  - HALT: start -> FETCH; otherwise stay. Simultaneous start and halt_req -> FETCH with halt_pending clear.
  - FAULT: sticky; exits only via rst. start is ignored.
- Timeout:
  - The counter clears on every entry to FETCH or MEM and increments each cycle in that state without ack.
  - "Timeout hit" means counter == TIMEOUT-1 with ack low, so FAULT is taken after exactly TIMEOUT ack-less cycles.
  - An ack arriving in that same cycle wins.
  - TIMEOUT=0: never hit.
- Latency with zero-wait memory: non-mem instruction is 4 cycles (FETCH, LOAD_REG, ALU, WB); mem instruction is 5 cycles; skipped instruction is 2 cycles.
- instr_count wraps from 2^CNT_W-1 to 0 without a flag.

Decomposition:
- Shared package: state encoding localparams (IDLE..FAULT) and STATE_W=3, reused by the datapath and the bench.
- Sub-module wait_timer: TO_CNT_W counter with clear, enable and hit output. Instantiated once and shared by FETCH and MEM; only one of them is active at a time.

Test Plan:
- Reset, then start pulse, then imem_ack=1 every FETCH, condition_code_check=1, is_mem_op=0 -> states 1,2,3,5,1 repeating; pc_inc one pulse per FETCH; instr_count=3 after 12 cycles.
- Mem instruction with dmem_ack delayed 3 cycles -> MEM held 4 cycles with dmem_req=1; instr_count increments once, in WB.
- condition_code_check=0 in LOAD_REG -> next state FETCH; no alu_en or wb_en; instr_count unchanged.
- halt_req pulse during ALU -> sequence ALU, WB, HALT (instruction retired, busy=0); start -> FETCH. is_halt_op in LOAD_REG -> HALT, count+1.
- TIMEOUT=15 with imem_ack held 0 -> FAULT after exactly 15 FETCH cycles, fault=1; start is ignored; rst clears to IDLE. Also: ack on the 15th cycle -> LOAD_REG, not FAULT.
- Extra checks: rst asserted mid-MEM -> immediate IDLE with all outputs 0. HAS_MEM_STAGE=0 with is_mem_op=1 -> ALU goes to WB. CNT_W=2 -> instr_count wraps 3 to 0.
